// File: rtl/tuner_pwr_detect_phy.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tuner_pwr_detect_phy : settle, average N ADC samples, strobe power.      |
// | Option: TUNER_PWR_DETECT_PEAK_TRACK_EN adds peak/tune-code tracking.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tuner_pwr_detect_phy #(
  parameter int ADC_WIDTH = 8,
  parameter int DAC_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_cfg_settle_cycles,
  input  logic [2:0]           i_cfg_avg_log2,
  input  logic                 i_adc_val,
  input  logic [ADC_WIDTH-1:0] i_adc_data,
  input  logic                 i_pwr_detect_active,
  input  logic                 i_pwr_detect_refresh,
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
  input  logic [DAC_WIDTH-1:0] i_dig_ring_tune,
  output logic [ADC_WIDTH-1:0] o_pwr_peak,
  output logic [DAC_WIDTH-1:0] o_pwr_peak_code,
`endif
  output logic                 o_pwr_detect_update,
  output logic [ADC_WIDTH-1:0] o_pwr_detect_pwr
);

  localparam int ACC_W = ADC_WIDTH + 4;

  if (ADC_WIDTH < 1 || DAC_WIDTH < 1) begin : g_param_check
    $error("tuner_pwr_detect_phy: widths must be >= 1");
  end

  typedef enum logic [1:0] {
    PD_IDLE   = 2'd0,
    PD_SETTLE = 2'd1,
    PD_ACCUM  = 2'd2,
    PD_UPDATE = 2'd3
  } pd_state_e;

  pd_state_e            state_q, state_d;
  logic [7:0]           settle_q, settle_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [2:0]           shift_q, shift_d;
  logic [ADC_WIDTH-1:0] pwr_q, pwr_d;

  logic [2:0]       shift_cfg;
  logic [ACC_W-1:0] sum;
  logic [4:0]       last_idx;

  assign shift_cfg = (i_cfg_avg_log2 > 3'd4) ? 3'd4 : i_cfg_avg_log2;
  assign sum       = acc_q + {4'b0000, i_adc_data};
  assign last_idx  = (5'd1 << shift_q) - 5'd1;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    pwr_d    = pwr_q;
    if (i_pwr_detect_refresh) begin
      state_d  = PD_IDLE;
      settle_d = 8'd0;
      acc_d    = '0;
      cnt_d    = 5'd0;
      pwr_d    = '0;
    end else begin
      case (state_q)
        PD_IDLE: begin
          if (i_pwr_detect_active) begin
            if (i_cfg_settle_cycles != 8'd0) begin
              state_d  = PD_SETTLE;
              settle_d = i_cfg_settle_cycles;
            end else begin
              state_d = PD_ACCUM;
              shift_d = shift_cfg;
            end
          end
        end
        PD_SETTLE: begin
          if (!i_pwr_detect_active) begin
            state_d = PD_IDLE;
          end else if (settle_q <= 8'd1) begin
            state_d = PD_ACCUM;
            shift_d = shift_cfg;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        PD_ACCUM: begin
          if (!i_pwr_detect_active) begin
            state_d = PD_IDLE;
            acc_d   = '0;
            cnt_d   = 5'd0;
          end else if (i_adc_val) begin
            acc_d = sum;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == last_idx) begin
              // Truncating divide by N; the sum already includes this sample.
              pwr_d   = sum[shift_q +: ADC_WIDTH];
              state_d = PD_UPDATE;
            end
          end
        end
        PD_UPDATE: begin
          acc_d = '0;
          cnt_d = 5'd0;
          if (i_pwr_detect_active) begin
            if (i_cfg_settle_cycles != 8'd0) begin
              state_d  = PD_SETTLE;
              settle_d = i_cfg_settle_cycles;
            end else begin
              state_d = PD_ACCUM;
              shift_d = shift_cfg;
            end
          end else begin
            state_d = PD_IDLE;
          end
        end
        default: state_d = PD_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= PD_IDLE;
      settle_q <= 8'd0;
      acc_q    <= '0;
      cnt_q    <= 5'd0;
      shift_q  <= 3'd0;
      pwr_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      pwr_q    <= pwr_d;
    end
  end

  // The strobe is a pure state decode, so a refresh arriving in PD_UPDATE
  // cannot suppress the strobe already being presented.
  assign o_pwr_detect_update = (state_q == PD_UPDATE);
  assign o_pwr_detect_pwr    = pwr_q;

`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
  logic [ADC_WIDTH-1:0] peak_q;
  logic [DAC_WIDTH-1:0] peak_code_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak_q      <= '0;
      peak_code_q <= '0;
    end else if (i_pwr_detect_refresh) begin
      peak_q      <= '0;
      peak_code_q <= '0;
    end else if (state_q == PD_UPDATE && pwr_q > peak_q) begin
      peak_q      <= pwr_q;
      peak_code_q <= i_dig_ring_tune;
    end
  end

  assign o_pwr_peak      = peak_q;
  assign o_pwr_peak_code = peak_code_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tuner_pwr_detect_phy.sv
`default_nettype none
// Bench for tuner_pwr_detect_phy: random and directed measurements against an
// arithmetic model of settle/average/strobe behaviour.
module tb_tuner_pwr_detect_phy;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int NSTIM = 600;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    cfg_settle;
  logic [2:0]    cfg_log2;
  logic          adc_val;
  logic [AW-1:0] adc_data;
  logic          active;
  logic          refresh;
  logic          upd;
  logic [AW-1:0] pwr;
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
  logic [DW-1:0] tune;
  logic [AW-1:0] peak;
  logic [DW-1:0] peak_code;
  int            m_peak;
  int            m_code;
`endif

  int checks = 0;
  int errors = 0;
  int last_pwr;

  bit            stim_val[NSTIM];
  logic [AW-1:0] stim_data[NSTIM];

  always #5 clk = ~clk;

  tuner_pwr_detect_phy #(.ADC_WIDTH(AW), .DAC_WIDTH(DW)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_cfg_settle_cycles  (cfg_settle),
    .i_cfg_avg_log2       (cfg_log2),
    .i_adc_val            (adc_val),
    .i_adc_data           (adc_data),
    .i_pwr_detect_active  (active),
    .i_pwr_detect_refresh (refresh),
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    .i_dig_ring_tune      (tune),
    .o_pwr_peak           (peak),
    .o_pwr_peak_code      (peak_code),
`endif
    .o_pwr_detect_update  (upd),
    .o_pwr_detect_pwr     (pwr)
  );

  task automatic fill_zero();
    for (int k = 0; k < NSTIM; k++) begin
      stim_val[k]  = 1'b0;
      stim_data[k] = AW'($urandom_range(0, 255));
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < NSTIM; k++) begin
      stim_val[k]  = ($urandom_range(0, 3) != 0);
      stim_data[k] = AW'($urandom_range(0, 255));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      active = 1'b0; adc_val = 1'b0; refresh = 1'b0;
      @(negedge clk);
      checks++;
      if (upd !== 1'b0) begin
        errors++; $display("FAIL idle_no_strobe: update=%b required 0", upd);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_refresh();
    refresh = 1'b1; active = 1'b0;
    @(posedge clk); #1;
    refresh = 1'b0;
    last_pwr = 0;
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    m_peak = 0; m_code = 0;
`endif
  endtask

  // One measurement from PD_IDLE using stim_val/stim_data indexed by cycle.
  task automatic run_meas(input int s, input int l2, input int tcode, output int obs_cyc);
    int n, acc, got, exp_cyc, exp_pwr, nstrobe, last;
    logic [AW-1:0] exp_v;
    n = 1 << ((l2 > 4) ? 4 : l2);
    acc = 0; got = 0; exp_cyc = -1;
    for (int k = s + 1; k < NSTIM && exp_cyc < 0; k++) begin
      if (stim_val[k]) begin
        acc += int'(stim_data[k]);
        got++;
        if (got == n) exp_cyc = k + 1;
      end
    end
    exp_pwr = acc / n;
    exp_v   = exp_pwr[AW-1:0];
    obs_cyc = -1;
    if (exp_cyc < 0 || exp_cyc + 3 >= NSTIM) begin
      checks++; errors++;
      $display("FAIL stim_gen: not enough samples (s=%0d n=%0d)", s, n);
      return;
    end
    last = exp_cyc + 3;
    cfg_settle = 8'(s); cfg_log2 = 3'(l2);
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    tune = DW'(tcode);
`endif
    nstrobe = 0;
    for (int k = 0; k <= last; k++) begin
      active   = (k < exp_cyc);
      adc_val  = stim_val[k];
      adc_data = stim_data[k];
      if (k > s) begin
        cfg_settle = 8'($urandom_range(0, 255));
        cfg_log2   = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      if (upd === 1'b1) begin
        nstrobe++;
        if (obs_cyc < 0) begin
          obs_cyc = k;
          checks++;
          if (pwr !== exp_v) begin
            errors++; $display("FAIL meas_pwr_at_strobe: got %0d required %0d", pwr, exp_v);
          end
        end
      end
      @(posedge clk); #1;
    end
    adc_val = 1'b0;
    checks++;
    if (nstrobe != 1) begin
      errors++; $display("FAIL meas_strobe_count: got %0d required 1", nstrobe);
    end
    checks++;
    if (obs_cyc != exp_cyc) begin
      errors++; $display("FAIL meas_strobe_cycle: got %0d required %0d (s=%0d l2=%0d)", obs_cyc, exp_cyc, s, l2);
    end
    checks++;
    if (pwr !== exp_v) begin
      errors++; $display("FAIL meas_pwr_held: got %0d required %0d", pwr, exp_v);
    end
    last_pwr = exp_pwr;
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    if (exp_pwr > m_peak) begin m_peak = exp_pwr; m_code = tcode; end
    checks++;
    if (peak !== AW'(m_peak) || peak_code !== DW'(m_code)) begin
      errors++; $display("FAIL meas_peak: got %0d@%0d required %0d@%0d", peak, peak_code, m_peak, m_code);
    end
`endif
  endtask

  task automatic test_reset();
    checks++;
    if (pwr !== '0 || upd !== 1'b0) begin
      errors++; $display("FAIL reset_state: pwr=%0d update=%b required 0/0", pwr, upd);
    end
  endtask

  task automatic test_averaging();
    int c;
    fill_zero();
    for (int i = 0; i < 4; i++) begin
      stim_val[3 + i]  = 1'b1;
      stim_data[3 + i] = AW'(10 * (i + 1));
    end
    run_meas(2, 2, 7, c);
    checks++;
    if (c != 7 || pwr !== 8'd25) begin
      errors++; $display("FAIL averaging: cycle=%0d pwr=%0d required 7/25", c, pwr);
    end
  endtask

  task automatic test_gaps();
    int c;
    fill_zero();
    stim_val[1] = 1'b1; stim_data[1] = 8'd100;
    stim_val[4] = 1'b1; stim_data[4] = 8'd200;
    run_meas(0, 1, 9, c);
    checks++;
    if (c != 5 || pwr !== 8'd150) begin
      errors++; $display("FAIL gaps: cycle=%0d pwr=%0d required 5/150", c, pwr);
    end
  endtask

  task automatic test_clamp();
    int c;
    fill_zero();
    for (int i = 1; i <= 16; i++) begin
      stim_val[i] = 1'b1; stim_data[i] = 8'd255;
    end
    run_meas(0, 7, 11, c);
    checks++;
    if (c != 17 || pwr !== 8'd255) begin
      errors++; $display("FAIL clamp: cycle=%0d pwr=%0d required 17/255", c, pwr);
    end
  endtask

  task automatic test_random();
    int c;
    for (int t = 0; t < 10; t++) begin
      fill_random();
      run_meas($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 255), c);
    end
  endtask

  task automatic test_refresh();
    cfg_settle = 8'd0; cfg_log2 = 3'd2;
    for (int k = 0; k < 4; k++) begin
      active  = 1'b1;
      adc_val = (k >= 1);
      adc_data = AW'($urandom_range(1, 255));
      refresh = (k == 3);
      @(negedge clk);
      checks++;
      if (upd !== 1'b0) begin
        errors++; $display("FAIL refresh_pre_strobe: update=%b required 0", upd);
      end
      @(posedge clk); #1;
    end
    refresh = 1'b0; active = 1'b0; adc_val = 1'b0;
    @(negedge clk);
    checks++;
    if (pwr !== '0) begin
      errors++; $display("FAIL refresh_clear: pwr=%0d required 0", pwr);
    end
    @(posedge clk); #1;
    idle_cycles(6);
    last_pwr = 0;
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    m_peak = 0; m_code = 0;
`endif
  endtask

  task automatic test_refresh_on_update();
    logic [AW-1:0] a, b, e;
    a = AW'($urandom_range(1, 255)); b = AW'($urandom_range(1, 255));
    e = AW'((int'(a) + int'(b)) / 2);
    cfg_settle = 8'd0; cfg_log2 = 3'd1;
    for (int k = 0; k < 5; k++) begin
      active   = (k < 3);
      adc_val  = (k == 1 || k == 2);
      adc_data = (k == 1) ? a : b;
      refresh  = (k == 3);
      @(negedge clk);
      if (k == 3) begin
        checks++;
        if (upd !== 1'b1 || pwr !== e) begin
          errors++; $display("FAIL refresh_on_update_strobe: update=%b pwr=%0d required 1/%0d", upd, pwr, e);
        end
      end
      if (k == 4) begin
        checks++;
        if (upd !== 1'b0 || pwr !== '0) begin
          errors++; $display("FAIL refresh_on_update_clear: update=%b pwr=%0d required 0/0", upd, pwr);
        end
      end
      @(posedge clk); #1;
    end
    refresh = 1'b0; adc_val = 1'b0;
    last_pwr = 0;
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    m_peak = 0; m_code = 0;
`endif
  endtask

  task automatic test_active_drop();
    int c;
    fill_zero();
    stim_val[1] = 1'b1; stim_data[1] = 8'd200;
    run_meas(0, 0, 1, c);
    cfg_settle = 8'd1; cfg_log2 = 3'd2;
    for (int k = 0; k < 4; k++) begin
      active = 1'b1; adc_val = (k >= 2); adc_data = 8'd250;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) begin
      active = 1'b0; adc_val = 1'b1;
      @(negedge clk);
      checks++;
      if (upd !== 1'b0 || pwr !== AW'(last_pwr)) begin
        errors++; $display("FAIL active_drop: update=%b pwr=%0d required 0/%0d", upd, pwr, last_pwr);
      end
      @(posedge clk); #1;
    end
    adc_val = 1'b0;
    fill_random();
    run_meas(1, 2, 2, c);
  endtask

  task automatic test_reset_mid_accum();
    int c;
    fill_zero();
    stim_val[1] = 1'b1; stim_data[1] = 8'd180;
    run_meas(0, 0, 3, c);
    cfg_settle = 8'd0; cfg_log2 = 3'd3;
    for (int k = 0; k < 4; k++) begin
      active = 1'b1; adc_val = (k >= 1); adc_data = 8'd99;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwr !== '0 || upd !== 1'b0) begin
      errors++; $display("FAIL reset_mid_accum: pwr=%0d update=%b required 0/0", pwr, upd);
    end
    active = 1'b0; adc_val = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_pwr = 0;
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    m_peak = 0; m_code = 0;
`endif
    idle_cycles(10);
    fill_random();
    run_meas(0, 3, 4, c);
  endtask

`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
  task automatic test_peak();
    int c;
    do_refresh();
    fill_zero(); stim_val[1] = 1'b1; stim_data[1] = 8'd50;
    run_meas(0, 0, 3, c);
    fill_zero(); stim_val[1] = 1'b1; stim_data[1] = 8'd80;
    run_meas(0, 0, 4, c);
    fill_zero(); stim_val[1] = 1'b1; stim_data[1] = 8'd80;
    run_meas(0, 0, 5, c);
    checks++;
    if (peak !== 8'd80 || peak_code !== 8'd4) begin
      errors++; $display("FAIL peak_ties: got %0d@%0d required 80@4", peak, peak_code);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_settle = 8'd0; cfg_log2 = 3'd0;
    adc_val = 1'b0; adc_data = '0; active = 1'b0; refresh = 1'b0;
    last_pwr = 0;
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    tune = '0; m_peak = 0; m_code = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_averaging();
    test_gaps();
    test_clamp();
    test_random();
    test_refresh();
    test_refresh_on_update();
    test_active_drop();
    test_reset_mid_accum();
`ifdef TUNER_PWR_DETECT_PEAK_TRACK_EN
    test_peak();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tuner_pwr_detect_phy.md
TUNER_PWR_DETECT_PHY -- requirements
Module: tuner_pwr_detect_phy

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 8, meaning the ADC sample width.
REQ-002 SHALL have parameter DAC_WIDTH, default 8, meaning the ring tune code width.
REQ-003 SHALL have port i_clk, input, 1, the single clock.
REQ-004 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port i_cfg_settle_cycles, input, 8, the idle cycles after a tune change before sampling.
REQ-006 SHALL have port i_cfg_avg_log2, input, 3, log2 of the averaged sample count.
REQ-007 SHALL have port i_adc_val, input, 1, ADC sample valid.
REQ-008 SHALL have port i_adc_data, input, ADC_WIDTH, ADC sample.
REQ-009 SHALL have port i_pwr_detect_active, input, 1, consumer requests measurements.
REQ-010 SHALL have port i_pwr_detect_refresh, input, 1, consumer clears the detector.
REQ-011 SHALL have port o_pwr_detect_update, output, 1, one-cycle strobe: a new averaged power is valid.
REQ-012 SHALL have port o_pwr_detect_pwr, output, ADC_WIDTH, the latest averaged power, held between updates.

Function
REQ-013 SHALL implement FSM states PD_IDLE, PD_SETTLE, PD_ACCUM, PD_UPDATE.
REQ-014 SHALL transition from PD_IDLE when active=1 and refresh=0: to PD_SETTLE if i_cfg_settle_cycles>0, else directly to PD_ACCUM.
REQ-015 SHALL, on entering PD_SETTLE, load a down-counter with i_cfg_settle_cycles, remain exactly that many cycles, then enter PD_ACCUM.
REQ-016 SHALL, on entering PD_ACCUM, latch N = 2^min(i_cfg_avg_log2,4), so values 5..7 clamp to 16 samples; config changes mid-measurement SHALL be ignored.
REQ-017 SHALL, in PD_ACCUM, add i_adc_data into an (ADC_WIDTH+4)-bit accumulator and increment a sample counter on each cycle with i_adc_val=1; cycles with i_adc_val=0 SHALL not count.
REQ-018 SHALL ignore i_adc_val in PD_IDLE, PD_SETTLE and PD_UPDATE.
REQ-019 SHALL, on the cycle the Nth sample is accepted, register o_pwr_detect_pwr = accumulator_including_sample >> log2(N) (truncating) and enter PD_UPDATE.
REQ-020 SHALL assert o_pwr_detect_update for exactly the one cycle spent in PD_UPDATE.
REQ-021 SHALL leave PD_UPDATE for PD_SETTLE or PD_ACCUM (per REQ-014 rule) if active=1, else PD_IDLE, and SHALL clear the accumulator and counter.
REQ-022 SHALL treat refresh=1 in any state as highest priority: next state PD_IDLE; accumulator, counter and o_pwr_detect_pwr cleared to 0; no update strobe.
REQ-023 SHALL, when active falls in PD_SETTLE or PD_ACCUM, go to PD_IDLE, discard the partial sum and retain o_pwr_detect_pwr.
REQ-024 SHALL, if refresh and update would coincide in PD_UPDATE, still output the strobe for that cycle (already in state) but clear per REQ-022 on the next edge.
REQ-025 SHALL give latency with contiguous samples, S=settle, N samples: update strobe in cycle S+N+1 after the cycle active is first sampled high.

Reset
REQ-026 SHALL, on i_rst_n=0, asynchronously set state to PD_IDLE; clear the accumulator, counters, o_pwr_detect_pwr; and set o_pwr_detect_update=0.
REQ-027 SHALL resume from PD_IDLE after reset release; a measurement in progress SHALL be lost without a strobe.

Configuration
REQ-028 SHALL, with TUNER_PWR_DETECT_PEAK_TRACK_EN defined, add input i_dig_ring_tune (DAC_WIDTH) and outputs o_pwr_peak (ADC_WIDTH), o_pwr_peak_code (DAC_WIDTH).
REQ-029 SHALL, when the macro is defined, update o_pwr_peak/o_pwr_peak_code on each update strobe where the new power > o_pwr_peak (strictly greater; ties keep the earlier code), capturing i_dig_ring_tune; both reset/refresh to 0.
REQ-030 SHALL, without the macro, omit these ports and logic entirely with otherwise identical behaviour.

Verification
REQ-031 SHALL verify reset: assert i_rst_n=0 mid-PD_ACCUM -> state PD_IDLE, pwr=0, update=0 immediately.
REQ-032 SHALL verify averaging: settle=2, avg_log2=2, active=1, samples 10,20,30,40 contiguous -> one update strobe at cycle 7, pwr=25.
REQ-033 SHALL verify gaps: avg_log2=1 with val pattern 1,0,0,1 (data 100,200) -> strobe delayed 2 cycles, pwr=150.
REQ-034 SHALL verify refresh: refresh=1 after 2 of 4 samples -> PD_IDLE, pwr=0, no strobe.
REQ-035 SHALL verify clamp: avg_log2=7 with 16 samples of 255 -> pwr=255, no overflow.
REQ-036 SHALL verify the peak macro: updates 50@code 3, 80@code 4, 80@code 5 -> o_pwr_peak=80, o_pwr_peak_code=4.
